// File: rtl/bsg_fifo_reorder_burst_issuer.sv
// Burst issuer for a reorder FIFO: reserves len contiguous slots in one cycle on
// command accept, then emits one tagged request per beat with id = base_id + beat.
module bsg_fifo_reorder_burst_issuer #(
  parameter int els_p        = 8,
  parameter int addr_width_p = 32,
  parameter int max_burst_p  = 4,
  localparam int id_w_lp  = $clog2(els_p),
  localparam int len_w_lp = $clog2(max_burst_p+1),
  localparam int cnt_w_lp = $clog2(els_p+1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    burst_v_i,
  input  logic [addr_width_p-1:0] burst_addr_i,
  input  logic [len_w_lp-1:0]     burst_len_i,
  output logic                    burst_ready_and_o,
  input  logic [cnt_w_lp-1:0]     alloc_v_count_i,
  input  logic [id_w_lp-1:0]      alloc_id_i,
  output logic [cnt_w_lp-1:0]     alloc_yumi_variable_o,
  output logic                    req_v_o,
  output logic [addr_width_p-1:0] req_addr_o,
  output logic [id_w_lp-1:0]      req_id_o,
  output logic                    req_last_o,
  input  logic                    req_ready_and_i,
  output logic                    busy_o
);

  typedef enum logic {IDLE, ISSUE} state_e;

  typedef struct packed {
    logic [addr_width_p-1:0] addr;
    logic [id_w_lp-1:0]      id;
    logic [len_w_lp-1:0]     len;
  } burst_s;

  state_e              state_r;
  burst_s              burst_r;
  logic [len_w_lp-1:0] cnt_r;
  logic                accept, beat;

  // Ready is gated by reset so nothing is granted while the FIFO is being cleared.
  assign burst_ready_and_o     = reset_n_i & (state_r == IDLE)
                               & (alloc_v_count_i >= cnt_w_lp'(burst_len_i));
  assign accept                = burst_v_i & burst_ready_and_o;
  assign alloc_yumi_variable_o = accept ? cnt_w_lp'(burst_len_i) : '0;

  assign req_v_o    = (state_r == ISSUE);
  assign busy_o     = (state_r == ISSUE);
  assign req_id_o   = burst_r.id + id_w_lp'(cnt_r);
  assign req_addr_o = burst_r.addr + addr_width_p'(cnt_r);
  assign req_last_o = (cnt_r == burst_r.len - len_w_lp'(1));
  assign beat       = req_v_o & req_ready_and_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      burst_r <= '0;
    end else begin
      case (state_r)
        IDLE: if (accept) begin
          state_r <= ISSUE;
          cnt_r   <= '0;
          burst_r <= '{addr: burst_addr_i, id: alloc_id_i, len: burst_len_i};
        end
        ISSUE: if (beat) begin
          if (req_last_o) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + len_w_lp'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_len_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    burst_v_i |-> (burst_len_i != '0 && burst_len_i <= len_w_lp'(max_burst_p)));
  a_cmd_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (burst_v_i && !burst_ready_and_o) |=>
      (!burst_v_i || ($stable(burst_addr_i) && $stable(burst_len_i))));
`endif

endmodule

// File: tb/tb_bsg_fifo_reorder_burst_issuer.sv
// Bench for bsg_fifo_reorder_burst_issuer: directed scenarios plus random traffic,
// checked against a queue of expected beats built when a burst is granted.
module tb_bsg_fifo_reorder_burst_issuer;
  localparam int ELS = 8, AW = 32, MB = 4;
  localparam int IW = $clog2(ELS), LW = $clog2(MB+1), CW = $clog2(ELS+1);

  logic          clk = 0, reset_n = 0;
  logic          burst_v = 0, burst_ready, req_v, req_last, req_ready = 1, busy;
  logic [AW-1:0] burst_addr = '0, req_addr;
  logic [LW-1:0] burst_len = 1;
  logic [CW-1:0] alloc_count = '0, yumi;
  logic [IW-1:0] alloc_id = '0, req_id;

  bsg_fifo_reorder_burst_issuer #(.els_p(ELS), .addr_width_p(AW), .max_burst_p(MB)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .burst_v_i(burst_v), .burst_addr_i(burst_addr), .burst_len_i(burst_len),
    .burst_ready_and_o(burst_ready),
    .alloc_v_count_i(alloc_count), .alloc_id_i(alloc_id), .alloc_yumi_variable_o(yumi),
    .req_v_o(req_v), .req_addr_o(req_addr), .req_id_o(req_id), .req_last_o(req_last),
    .req_ready_and_i(req_ready), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [IW-1:0] id; logic [AW-1:0] addr; logic last; } beat_t;
  beat_t q[$];
  int checks = 0, errors = 0, popped = 0;
  logic last_acc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance the model.
  task automatic step();
    logic rdy, acc, pop;
    beat_t nb[$];
    @(negedge clk);
    rdy = reset_n && (q.size() == 0) && (int'(alloc_count) >= int'(burst_len));
    acc = burst_v && rdy;
    pop = reset_n && (q.size() != 0) && req_ready;
    check("ready", 64'(burst_ready), 64'(rdy));
    check("yumi",  64'(yumi), acc ? 64'(burst_len) : 64'd0);
    check("req_v", 64'(req_v), 64'(q.size() != 0));
    check("busy",  64'(busy),  64'(q.size() != 0));
    if (q.size() != 0) begin
      check("id",   64'(req_id),   64'(q[0].id));
      check("addr", 64'(req_addr), 64'(q[0].addr));
      check("last", 64'(req_last), 64'(q[0].last));
    end
    if (acc)
      for (int i = 0; i < int'(burst_len); i++) begin
        beat_t b;
        b.id   = IW'((int'(alloc_id) + i) % ELS);
        b.addr = burst_addr + AW'(i);
        b.last = (i == int'(burst_len) - 1);
        nb.push_back(b);
      end
    @(posedge clk);
    if (!reset_n) q.delete();
    else if (acc) q = nb;
    else if (pop) begin void'(q.pop_front()); popped++; end
    last_acc = acc;
    #1;
  endtask

  task automatic drain();
    req_ready = 1;
    for (int k = 0; k < 40 && q.size() != 0; k++) step();
    check("drain", 64'(q.size()), 64'd0);
    step();
  endtask

  task automatic issue(input logic [AW-1:0] a, input int len, input int id);
    burst_addr = a; burst_len = LW'(len); alloc_id = IW'(id); burst_v = 1;
    alloc_count = CW'(ELS);
    step();
    burst_v = 0;
  endtask

  initial begin
    int p0;
    // reset holds everything low even with a command pending
    reset_n = 0; burst_v = 1; burst_len = 1; alloc_count = CW'(ELS);
    #1;
    repeat (2) step();
    check("rst_req_v", 64'(req_v), 64'd0);
    burst_v = 0; reset_n = 1;
    step();

    // wrap of ids 6,7,0,1 with yumi=4
    issue(32'h100, 4, 6);
    drain();

    // ready withheld until enough slots
    burst_addr = 32'h200; burst_len = 3; alloc_id = 2; alloc_count = 2; burst_v = 1;
    step(); step();
    alloc_count = 3;
    step();
    check("acc_at_3", 64'(last_acc), 64'd1);
    burst_v = 0;
    drain();

    // backpressure at beat 1
    p0 = popped;
    issue(32'h300, 4, 5);
    step();
    req_ready = 0;
    repeat (3) step();
    drain();
    check("beats4", 64'(popped - p0), 64'd4);

    // reset mid-burst aborts immediately
    issue(32'h400, 4, 1);
    step();
    reset_n = 0;
    #1;
    check("abort_req_v", 64'(req_v), 64'd0);
    check("abort_busy",  64'(busy),  64'd0);
    q.delete();
    repeat (2) step();
    reset_n = 1;
    step();
    issue(32'h500, 2, 0);
    drain();

    // back-to-back single-beat bursts
    burst_addr = 32'h0; burst_len = 1; alloc_id = 2; alloc_count = CW'(ELS); burst_v = 1;
    step();
    burst_addr = 32'h8; alloc_id = 3;
    step();
    check("b2b_no_acc", 64'(last_acc), 64'd0);
    step();
    check("b2b_acc", 64'(last_acc), 64'd1);
    burst_v = 0;
    drain();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      alloc_count = CW'($urandom_range(0, ELS));
      alloc_id    = IW'($urandom_range(0, ELS-1));
      req_ready   = ($urandom_range(0, 3) != 0);
      if (!burst_v || last_acc) begin
        burst_v    = ($urandom_range(0, 1) != 0);
        burst_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : AW'($urandom);
        burst_len  = LW'($urandom_range(1, MB));
      end
      step();
    end
    burst_v = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
